// File: rtl/irq_pending_latch.sv
// irq_pending_latch: synchronizes four request lines, latches rising edges
// as sticky pending bits, and presents a masked vector to the encoder.
module irq_pending_latch #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_in,
    input  logic       mask_wr,
    input  logic [3:0] mask_wdata,
    input  logic       ack,
    input  logic [1:0] ack_idx,
    input  logic       ovf_clr,
    output logic [3:0] pending,
    output logic       any_pending,
    output logic [3:0] raw_pending,
    output logic [3:0] mask,
    output logic [3:0] ovf,
    output logic       ack_err
);

    logic [3:0] sync [SYNC_STAGES];
    logic [3:0] prev;
    logic [3:0] rise;
    logic [3:0] ack_dec;
    logic [3:0] clr;
    logic [3:0] ovf_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync[k] <= '0;
            end
            prev <= '0;
        end else begin
            sync[0] <= req_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync[k] <= sync[k-1];
            end
            prev <= sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        rise    = sync[SYNC_STAGES-1] & ~prev;
        ack_dec = ack ? (4'(1) << ack_idx) : 4'b0000;
        clr     = ack_dec & raw_pending;
        ovf_set = rise & raw_pending & ~clr;
    end

    // A new rise wins over a coincident ack or overflow clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_pending <= '0;
            ovf         <= '0;
            mask        <= '0;
            ack_err     <= 1'b0;
        end else begin
            raw_pending <= rise | (raw_pending & ~clr);
            ovf         <= ovf_clr ? ovf_set : (ovf | ovf_set);
            ack_err     <= ack & ~raw_pending[ack_idx];
            if (mask_wr) begin
                mask <= mask_wdata;
            end
        end
    end

    assign pending     = raw_pending & ~mask;
    assign any_pending = |pending;

endmodule

// File: tb/tb_irq_pending_latch.sv
// tb_irq_pending_latch: directed scenarios with hand-computed expectations
// for capture, ack, masking, overflow and asynchronous reset.
module tb_irq_pending_latch;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_in;
    logic       mask_wr;
    logic [3:0] mask_wdata;
    logic       ack;
    logic [1:0] ack_idx;
    logic       ovf_clr;
    logic [3:0] pending;
    logic       any_pending;
    logic [3:0] raw_pending;
    logic [3:0] mask;
    logic [3:0] ovf;
    logic       ack_err;

    int checks = 0;
    int failures = 0;

    irq_pending_latch #(.SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .req_in(req_in),
        .mask_wr(mask_wr),
        .mask_wdata(mask_wdata),
        .ack(ack),
        .ack_idx(ack_idx),
        .ovf_clr(ovf_clr),
        .pending(pending),
        .any_pending(any_pending),
        .raw_pending(raw_pending),
        .mask(mask),
        .ovf(ovf),
        .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-edge-wide pulse; the event is in raw_pending after the third tick.
    task automatic pulse(input logic [3:0] v);
        req_in = v;
        tick();
        req_in = 4'b0000;
        tick();
        tick();
    endtask

    task automatic do_ack(input logic [1:0] idx);
        ack = 1'b1;
        ack_idx = idx;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_in = 4'b0000;
        mask_wr = 1'b0;
        mask_wdata = 4'b0000;
        ack = 1'b0;
        ack_idx = 2'd0;
        ovf_clr = 1'b0;
        tick();
        tick();
        checks++;
        if ({raw_pending, pending, mask, ovf, any_pending, ack_err} !== 18'd0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0",
                     {raw_pending, pending, mask, ovf, any_pending, ack_err});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_capture();
        req_in = 4'b0100;
        tick();
        req_in = 4'b0000;
        tick();
        checks++;
        if (raw_pending !== 4'b0000) begin
            failures++;
            $display("FAIL capture_early got=%b exp=0000", raw_pending);
        end
        tick();
        checks++;
        if (raw_pending !== 4'b0100 || pending !== 4'b0100 || any_pending !== 1'b1) begin
            failures++;
            $display("FAIL capture_edge3 raw=%b pend=%b any=%b exp=0100/0100/1",
                     raw_pending, pending, any_pending);
        end
        do_ack(2'd2);
        checks++;
        if (pending !== 4'b0000 || ack_err !== 1'b0) begin
            failures++;
            $display("FAIL capture_ack pend=%b err=%b exp=0000/0", pending, ack_err);
        end
    endtask

    task automatic test_multi();
        pulse(4'b1011);
        checks++;
        if (pending !== 4'b1011) begin
            failures++;
            $display("FAIL multi_set got=%b exp=1011", pending);
        end
        do_ack(2'd3);
        checks++;
        if (pending !== 4'b0011) begin
            failures++;
            $display("FAIL multi_ack3 got=%b exp=0011", pending);
        end
        do_ack(2'd1);
        checks++;
        if (pending !== 4'b0001) begin
            failures++;
            $display("FAIL multi_ack1 got=%b exp=0001", pending);
        end
        do_ack(2'd0);
        checks++;
        if (pending !== 4'b0000 || any_pending !== 1'b0) begin
            failures++;
            $display("FAIL multi_ack0 got=%b any=%b exp=0000/0", pending, any_pending);
        end
    endtask

    task automatic test_mask();
        mask_wr = 1'b1;
        mask_wdata = 4'b0001;
        tick();
        mask_wr = 1'b0;
        checks++;
        if (mask !== 4'b0001) begin
            failures++;
            $display("FAIL mask_write got=%b exp=0001", mask);
        end
        pulse(4'b0001);
        checks++;
        if (raw_pending !== 4'b0001 || pending !== 4'b0000 || any_pending !== 1'b0) begin
            failures++;
            $display("FAIL mask_gate raw=%b pend=%b any=%b exp=0001/0000/0",
                     raw_pending, pending, any_pending);
        end
        mask_wr = 1'b1;
        mask_wdata = 4'b0000;
        tick();
        mask_wr = 1'b0;
        checks++;
        if (pending !== 4'b0001 || any_pending !== 1'b1) begin
            failures++;
            $display("FAIL mask_release pend=%b any=%b exp=0001/1", pending, any_pending);
        end
        do_ack(2'd0);
    endtask

    task automatic test_overflow();
        pulse(4'b0010);
        pulse(4'b0010);
        checks++;
        if (ovf !== 4'b0010 || raw_pending !== 4'b0010) begin
            failures++;
            $display("FAIL ovf_set ovf=%b raw=%b exp=0010/0010", ovf, raw_pending);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 4'b0000) begin
            failures++;
            $display("FAIL ovf_clr got=%b exp=0000", ovf);
        end
        // Overflow on line 0 so the coincident clear has another bit to drop.
        pulse(4'b0001);
        pulse(4'b0001);
        req_in = 4'b0010;
        tick();
        req_in = 4'b0000;
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 4'b0010) begin
            failures++;
            $display("FAIL ovf_clr_coincide got=%b exp=0010", ovf);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        do_ack(2'd1);
        do_ack(2'd0);
        checks++;
        if (raw_pending !== 4'b0000 || ovf !== 4'b0000) begin
            failures++;
            $display("FAIL ovf_cleanup raw=%b ovf=%b exp=0000/0000", raw_pending, ovf);
        end
    endtask

    task automatic test_back_to_back();
        pulse(4'b0010);
        req_in = 4'b0010;
        tick();
        req_in = 4'b0000;
        tick();
        ack = 1'b1;
        ack_idx = 2'd1;
        tick();
        ack = 1'b0;
        checks++;
        if (raw_pending !== 4'b0010 || ovf !== 4'b0000) begin
            failures++;
            $display("FAIL ack_vs_rise raw=%b ovf=%b exp=0010/0000", raw_pending, ovf);
        end
        do_ack(2'd2);
        checks++;
        if (ack_err !== 1'b1 || raw_pending !== 4'b0010 || ovf !== 4'b0000) begin
            failures++;
            $display("FAIL ack_err_pulse err=%b raw=%b ovf=%b exp=1/0010/0000",
                     ack_err, raw_pending, ovf);
        end
        tick();
        checks++;
        if (ack_err !== 1'b0 || raw_pending !== 4'b0010) begin
            failures++;
            $display("FAIL ack_err_one_cycle err=%b raw=%b exp=0/0010", ack_err, raw_pending);
        end
        do_ack(2'd1);
    endtask

    task automatic test_reset_mid();
        pulse(4'b0001);
        pulse(4'b0001);
        mask_wr = 1'b1;
        mask_wdata = 4'hF;
        tick();
        mask_wr = 1'b0;
        checks++;
        if (mask !== 4'hF || ovf !== 4'b0001 || raw_pending !== 4'b0001) begin
            failures++;
            $display("FAIL pre_reset mask=%h ovf=%b raw=%b exp=f/0001/0001",
                     mask, ovf, raw_pending);
        end
        req_in = 4'b1000;
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({raw_pending, pending, mask, ovf, any_pending, ack_err} !== 18'd0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0",
                     {raw_pending, pending, mask, ovf, any_pending, ack_err});
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (raw_pending !== 4'b0000) begin
            failures++;
            $display("FAIL post_reset_early got=%b exp=0000", raw_pending);
        end
        tick();
        checks++;
        if (pending !== 4'b1000 || any_pending !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_event pend=%b any=%b exp=1000/1", pending, any_pending);
        end
        tick();
        tick();
        checks++;
        if (raw_pending !== 4'b1000 || ovf !== 4'b0000) begin
            failures++;
            $display("FAIL post_reset_single raw=%b ovf=%b exp=1000/0000", raw_pending, ovf);
        end
        req_in = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_multi();
        test_mask();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_pending_latch.md
# irq_pending_latch

Request capture stage that sits directly upstream of the 4-to-2 priority encoder. It synchronizes four asynchronous request lines, detects rising edges, and holds each event as a sticky pending bit until a downstream consumer acknowledges it by index. It presents a masked pending vector for the encoder to arbitrate and flags events lost to overflow.

## Interface
- SYNC_STAGES, 2, depth of the per-line input synchronizer; legal range 1..3.

- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_in  in  4  asynchronous request lines; an event is a 0->1 transition.
- mask_wr  in  1  write strobe for the mask register.
- mask_wdata  in  4  new mask value; bit = 1 masks that line.
- ack  in  1  one-cycle acknowledge from the consumer.
- ack_idx  in  2  index of the line being acknowledged.
- ovf_clr  in  1  clears all overflow flags.
- pending  out  4  raw_pending & ~mask; drives the encoder input.
- any_pending  out  1  |pending.
- raw_pending  out  4  unmasked sticky event bits.
- mask  out  4  current mask register.
- ovf  out  4  sticky per-line overflow flags.
- ack_err  out  1  one-cycle pulse when the ack targets a non-pending line.

## Operation
- Per line i: sync chain s[0..SYNC_STAGES-1] and edge flop prev, with prev <= s[last]. rise[i] = s[last] & ~prev (combinational).
- Set/clear of raw_pending[i] on each edge:
  - clr_i = ack & (ack_idx == i) & raw_pending[i].
  - raw_pending[i] <= rise[i] | (raw_pending[i] & ~clr_i).
  - If set and clear coincide, set wins: the acked event is consumed and the new event stays pending.
- Overflow: ovf[i] <= 1 when rise[i] & raw_pending[i] & ~clr_i. The flag is sticky until ovf_clr.
  - ovf_clr in the same cycle as a new overflow: the set wins for that bit, and the other bits clear.
- ack_err <= ack & ~raw_pending[ack_idx]. This is a registered one-cycle pulse, and the ack causes no state change.
- Masking gates only the pending outputs. A masked line still captures events, can overflow, and can be acked.
- Mask register: mask <= mask_wdata on mask_wr. The new value is visible on mask and pending from the next cycle.
- pending and any_pending are combinational from registers, with no extra delay.
- Reset (asynchronous, any time, including mid-event):
  - sync chains, prev, raw_pending, ovf, mask and ack_err all go to 0.
  - pending = 0 and any_pending = 0.
  - Events in flight in the synchronizer are discarded.
  - A line held high through reset release produces exactly one event, because prev is 0.

## Timing
- Capture latency: with req_in rising before edge 1, raw_pending[i] is 1 after edge SYNC_STAGES+1. With the default of 2, that is after edge 3.
- A req_in high pulse must span at least one clk edge to be guaranteed captured. Back-to-back events need req_in low for at least one sampled edge.
- Ack latency: an ack sampled at edge k clears raw_pending and pending after edge k, and ack_err is valid after edge k.
- The consumer may ack on every cycle. There is no ready/back-pressure signal, and this block never stalls.

## Test plan
- Reset, then pulse req_in[2]:
  - raw_pending = 4'b0100 and pending = 4'b0100 exactly 3 edges later.
  - any_pending = 1.
  - ack with ack_idx = 2 -> pending = 0 the next cycle, ack_err = 0.
- Events on lines 0, 1 and 3 in the same cycle -> pending = 4'b1011. Then:
  - ack 3 -> 4'b0011.
  - ack 1 -> 4'b0001.
  - ack 0 -> 4'b0000.
- Write mask 4'b0001, then raise req_in[0]:
  - raw_pending = 4'b0001 and pending = 0, any_pending = 0.
  - Write mask 0 -> pending = 4'b0001 the next cycle.
- Second edge on line 1 while it is still pending -> ovf = 4'b0010 and raw_pending[1] stays 1. Then:
  - ovf_clr -> ovf = 0.
  - Repeat with ovf_clr coinciding with the overflow -> ovf[1] = 1.
- ack of line 1 in the same cycle as a new rise on line 1 -> raw_pending[1] stays 1, ovf[1] stays 0. Then ack with ack_idx = 2 while line 2 is idle -> ack_err pulses for 1 cycle and the state is unchanged.
- Assert rst mid-synchronization (req_in[3] rose 1 edge earlier), with mask = 4'hF and ovf nonzero:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - With req_in[3] still high at reset release -> pending = 4'b1000 after 3 edges.
